multicycle_cu: RTL and testbench

Multi-cycle sequencing control unit for the 16-bit accumulator datapath (PC, instruction ROM, ALU, ACC, data memory, four 4:1 muxes). It replaces single-cycle combinational decode with a Moore FSM: each instruction runs as FETCH, DECODE and EXEC steps, plus an optional WB step. Every datapath strobe is therefore a one-cycle pulse in a known state. It also provides halt, illegal-opcode and retired-instruction status for the bench.

---
 rtl/multicycle_cu_if.sv | 36 +++
 rtl/multicycle_cu.sv | 137 +++++++++++++
 tb/tb_multicycle_cu.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cu_if.sv
// Control bundle between the multi-cycle sequencer and the accumulator datapath.
// The sequencer takes the master side; the datapath or bench takes the slave side.
interface multicycle_cu_if;
  logic [5:0]  op;
  logic        acc_zero;
  logic        ir_wr_en;
  logic        pc_rst;
  logic        pc_run;
  logic        pc_wr_en;
  logic        acc_rst;
  logic        acc_wr_en;
  logic        mm_wr_en;
  logic [2:0]  alu_op;
  logic [1:0]  mux1_select;
  logic [1:0]  mux2_select;
  logic [1:0]  mux3_select;
  logic [1:0]  mux4_select;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  modport master (
    input  op, acc_zero,
    output ir_wr_en, pc_rst, pc_run, pc_wr_en, acc_rst, acc_wr_en, mm_wr_en,
    output alu_op, mux1_select, mux2_select, mux3_select, mux4_select,
    output state, halted, illegal, retired
  );

  modport slave (
    output op, acc_zero,
    input  ir_wr_en, pc_rst, pc_run, pc_wr_en, acc_rst, acc_wr_en, mm_wr_en,
    input  alu_op, mux1_select, mux2_select, mux3_select, mux4_select,
    input  state, halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_cu.sv
// Moore sequencer for the accumulator datapath: FETCH/DECODE/EXEC(/WB) per instruction,
// with halt, illegal-opcode and retired-instruction status.
module multicycle_cu (
  input  logic           clk,
  input  logic           rst,
  multicycle_cu_if.master bus
);
  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_LDA = 6'b000001;
  localparam logic [5:0] OP_STA = 6'b000010;
  localparam logic [5:0] OP_ADD = 6'b000011;
  localparam logic [5:0] OP_SUB = 6'b000100;
  localparam logic [5:0] OP_AND = 6'b000101;
  localparam logic [5:0] OP_JMP = 6'b000110;
  localparam logic [5:0] OP_JZ  = 6'b000111;
  localparam logic [5:0] OP_CLR = 6'b001000;
  localparam logic [5:0] OP_HLT = 6'b111111;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [5:0]  r_op_q;
  logic [15:0] r_retired;
  logic        w_needs_wb;
  logic        w_is_alu;
  logic        w_retire;
  logic [2:0]  w_alu_op;

  always_comb begin
    w_needs_wb = (r_op_q == OP_LDA) || (r_op_q == OP_ADD) ||
                 (r_op_q == OP_SUB) || (r_op_q == OP_AND);
    w_is_alu   = (r_op_q == OP_ADD) || (r_op_q == OP_SUB) || (r_op_q == OP_AND);
    w_alu_op   = 3'b000;
    if (r_op_q == OP_SUB) w_alu_op = 3'b001;
    if (r_op_q == OP_AND) w_alu_op = 3'b010;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (bus.op == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC:   w_next = w_needs_wb ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_RST;
    endcase
  end

  // HLT retires on entering HALT; everything else retires on its return to FETCH.
  assign w_retire = ((r_state == S_EXEC) && !w_needs_wb) || (r_state == S_WB) ||
                    ((r_state == S_DECODE) && (bus.op == OP_HLT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RST;
      r_op_q    <= 6'd0;
      r_retired <= 16'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_DECODE) && (bus.op != OP_HLT)) r_op_q <= bus.op;
      if (w_retire) r_retired <= r_retired + 16'd1;
    end
  end

  always_comb begin
    bus.ir_wr_en    = 1'b0;
    bus.pc_rst      = 1'b0;
    bus.pc_run      = 1'b0;
    bus.pc_wr_en    = 1'b0;
    bus.acc_rst     = 1'b0;
    bus.acc_wr_en   = 1'b0;
    bus.mm_wr_en    = 1'b0;
    bus.alu_op      = 3'b000;
    bus.mux1_select = 2'b00;
    bus.mux2_select = 2'b00;
    bus.mux3_select = 2'b00;
    bus.mux4_select = 2'b00;
    bus.halted      = 1'b0;
    bus.illegal     = 1'b0;
    case (r_state)
      S_RST: begin
        bus.pc_rst  = 1'b1;
        bus.acc_rst = 1'b1;
      end
      S_FETCH: bus.ir_wr_en = 1'b1;
      S_EXEC: begin
        case (r_op_q)
          OP_NOP: bus.pc_run = 1'b1;
          OP_LDA, OP_ADD, OP_SUB, OP_AND: begin
            bus.mux2_select = 2'b01;
            bus.alu_op      = w_alu_op;
          end
          OP_STA: begin
            bus.mm_wr_en = 1'b1;
            bus.pc_run   = 1'b1;
          end
          OP_JMP: bus.pc_wr_en = 1'b1;
          // acc_zero only matters here; mux4 stays on imm for the jump target
          OP_JZ: begin
            bus.pc_wr_en = bus.acc_zero;
            bus.pc_run   = !bus.acc_zero;
          end
          OP_CLR: begin
            bus.acc_rst = 1'b1;
            bus.pc_run  = 1'b1;
          end
          default: begin
            bus.illegal = 1'b1;
            bus.pc_run  = 1'b1;
          end
        endcase
      end
      S_WB: begin
        bus.acc_wr_en = 1'b1;
        bus.pc_run    = 1'b1;
        if (w_is_alu) begin
          bus.mux1_select = 2'b01;
          bus.mux2_select = 2'b01;
          bus.alu_op      = w_alu_op;
        end
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.state   = r_state;
  assign bus.retired = r_retired;
endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for the multi-cycle sequencer: drives opcodes per instruction and checks
// state walk, strobes and retired count against hand-computed values.
module tb_multicycle_cu;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_ret;
  int   cnt;

  multicycle_cu_if bus ();

  multicycle_cu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic any_strobe();
    return bus.ir_wr_en | bus.pc_rst | bus.pc_run | bus.pc_wr_en | bus.acc_rst |
           bus.acc_wr_en | bus.mm_wr_en | bus.illegal;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.op = 6'd0;
    bus.acc_zero = 1'b0;
    tick();
    tick();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.state); end
    checks++; if ({bus.pc_rst, bus.acc_rst} !== 2'b11) begin errors++; $display("FAIL rst_clears got %b exp 11", {bus.pc_rst, bus.acc_rst}); end
    checks++; if (bus.retired !== 16'd0) begin errors++; $display("FAIL rst_retired got %0d exp 0", bus.retired); end
    checks++; if ({bus.ir_wr_en, bus.pc_run, bus.pc_wr_en, bus.acc_wr_en, bus.mm_wr_en, bus.halted, bus.illegal} !== 7'd0)
      begin errors++; $display("FAIL rst_others got %b exp 0", {bus.ir_wr_en, bus.pc_run, bus.pc_wr_en, bus.acc_wr_en, bus.mm_wr_en, bus.halted, bus.illegal}); end
    rst = 1'b0;
    exp_ret = 0;
    tick();
    checks++; if (bus.state !== 3'd1 || bus.ir_wr_en !== 1'b1)
      begin errors++; $display("FAIL rst_first_fetch got state %0d ir %b exp 1 1", bus.state, bus.ir_wr_en); end
  endtask

  task automatic test_add();
    bus.op = 6'b000011;
    tick();
    checks++; if (bus.state !== 3'd2 || any_strobe() !== 1'b0)
      begin errors++; $display("FAIL add_decode got state %0d strobe %b exp 2 0", bus.state, any_strobe()); end
    tick();
    checks++; if (bus.state !== 3'd3 || bus.alu_op !== 3'b000 || bus.mux2_select !== 2'b01 || bus.mux3_select !== 2'b00)
      begin errors++; $display("FAIL add_exec got st %0d alu %b m2 %b m3 %b exp 3 000 01 00", bus.state, bus.alu_op, bus.mux2_select, bus.mux3_select); end
    checks++; if ({bus.acc_wr_en, bus.pc_run, bus.pc_wr_en} !== 3'b000)
      begin errors++; $display("FAIL add_exec_nowrite got %b exp 000", {bus.acc_wr_en, bus.pc_run, bus.pc_wr_en}); end
    tick();
    checks++; if (bus.state !== 3'd4 || bus.acc_wr_en !== 1'b1 || bus.mux1_select !== 2'b01 || bus.pc_run !== 1'b1)
      begin errors++; $display("FAIL add_wb got st %0d accwr %b m1 %b run %b exp 4 1 01 1", bus.state, bus.acc_wr_en, bus.mux1_select, bus.pc_run); end
    tick();
    exp_ret++;
    checks++; if (bus.state !== 3'd1 || bus.retired !== 16'(exp_ret))
      begin errors++; $display("FAIL add_done got st %0d ret %0d exp 1 %0d", bus.state, bus.retired, exp_ret); end
  endtask

  task automatic test_sta();
    bus.op = 6'b000010;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.mm_wr_en === 1'b1) begin
        cnt++;
        checks++; if (bus.state !== 3'd3 || bus.pc_run !== 1'b1)
          begin errors++; $display("FAIL sta_pulse got st %0d run %b exp 3 1", bus.state, bus.pc_run); end
      end
      tick();
    end
    exp_ret++;
    checks++; if (cnt != 1) begin errors++; $display("FAIL sta_count got %0d exp 1", cnt); end
    checks++; if (bus.state !== 3'd1 || bus.retired !== 16'(exp_ret))
      begin errors++; $display("FAIL sta_done got st %0d ret %0d exp 1 %0d", bus.state, bus.retired, exp_ret); end
  endtask

  task automatic test_jz();
    for (int z = 1; z >= 0; z--) begin
      bus.op = 6'b000111;
      bus.acc_zero = z[0];
      tick();
      tick();
      if (z == 1) begin
        checks++; if ({bus.pc_wr_en, bus.pc_run, bus.mux4_select} !== 4'b1000)
          begin errors++; $display("FAIL jz_taken got wr/run/m4 %b exp 1000", {bus.pc_wr_en, bus.pc_run, bus.mux4_select}); end
      end else begin
        checks++; if ({bus.pc_wr_en, bus.pc_run} !== 2'b01)
          begin errors++; $display("FAIL jz_not_taken got wr/run %b exp 01", {bus.pc_wr_en, bus.pc_run}); end
      end
      tick();
      exp_ret++;
      checks++; if (bus.state !== 3'd1 || bus.retired !== 16'(exp_ret))
        begin errors++; $display("FAIL jz_done got st %0d ret %0d exp 1 %0d", bus.state, bus.retired, exp_ret); end
    end
    bus.acc_zero = 1'b0;
  endtask

  task automatic test_illegal();
    bus.op = 6'b101010;
    tick();
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL ill_decode got %b exp 0", bus.illegal); end
    tick();
    checks++; if (bus.illegal !== 1'b1 || bus.pc_run !== 1'b1 || bus.pc_wr_en !== 1'b0)
      begin errors++; $display("FAIL ill_exec got ill %b run %b wr %b exp 1 1 0", bus.illegal, bus.pc_run, bus.pc_wr_en); end
    tick();
    exp_ret++;
    checks++; if (bus.illegal !== 1'b0 || bus.state !== 3'd1 || bus.retired !== 16'(exp_ret))
      begin errors++; $display("FAIL ill_done got ill %b st %0d ret %0d exp 0 1 %0d", bus.illegal, bus.state, bus.retired, exp_ret); end
  endtask

  task automatic test_ops();
    // op, exec alu_op, wb mux1, has wb
    logic [5:0] ops  [5] = '{6'b000100, 6'b000101, 6'b000001, 6'b001000, 6'b000110};
    logic [2:0] alus [5] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
    logic [1:0] m1s  [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    logic       wbs  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      bus.op = ops[k];
      tick();
      tick();
      if (ops[k] == 6'b001000) begin
        checks++; if ({bus.acc_rst, bus.pc_run, bus.pc_wr_en} !== 3'b110)
          begin errors++; $display("FAIL clr_exec got %b exp 110", {bus.acc_rst, bus.pc_run, bus.pc_wr_en}); end
      end else if (ops[k] == 6'b000110) begin
        checks++; if ({bus.pc_wr_en, bus.pc_run, bus.mux4_select} !== 4'b1000)
          begin errors++; $display("FAIL jmp_exec got %b exp 1000", {bus.pc_wr_en, bus.pc_run, bus.mux4_select}); end
      end else if (ops[k] != 6'b000001) begin
        checks++; if (bus.alu_op !== alus[k] || bus.mux2_select !== 2'b01)
          begin errors++; $display("FAIL op%0d_exec got alu %b m2 %b exp %b 01", k, bus.alu_op, bus.mux2_select, alus[k]); end
      end
      tick();
      if (wbs[k]) begin
        checks++; if (bus.state !== 3'd4 || bus.mux1_select !== m1s[k] || bus.acc_wr_en !== 1'b1 || bus.alu_op !== alus[k])
          begin errors++; $display("FAIL op%0d_wb got st %0d m1 %b wr %b alu %b exp 4 %b 1 %b", k, bus.state, bus.mux1_select, bus.acc_wr_en, bus.alu_op, m1s[k], alus[k]); end
        tick();
      end
      exp_ret++;
      checks++; if (bus.state !== 3'd1 || bus.retired !== 16'(exp_ret))
        begin errors++; $display("FAIL op%0d_done got st %0d ret %0d exp 1 %0d", k, bus.state, bus.retired, exp_ret); end
    end
  endtask

  task automatic test_halt_and_reset();
    bus.op = 6'b111111;
    tick();
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL hlt_decode got %b exp 0", bus.halted); end
    tick();
    exp_ret++;
    checks++; if (bus.state !== 3'd5 || bus.halted !== 1'b1 || bus.retired !== 16'(exp_ret))
      begin errors++; $display("FAIL hlt_enter got st %0d h %b ret %0d exp 5 1 %0d", bus.state, bus.halted, bus.retired, exp_ret); end
    bus.op = 6'b000011;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (any_strobe() !== 1'b0 || bus.halted !== 1'b1 || bus.retired !== 16'(exp_ret)) cnt++;
      tick();
    end
    checks++; if (cnt != 0) begin errors++; $display("FAIL hlt_quiet got %0d bad cycles exp 0", cnt); end
    rst = 1'b1;
    tick();
    checks++; if (bus.state !== 3'd0 || bus.halted !== 1'b0 || bus.retired !== 16'd0)
      begin errors++; $display("FAIL hlt_rst got st %0d h %b ret %0d exp 0 0 0", bus.state, bus.halted, bus.retired); end
    rst = 1'b0;
    tick();
    bus.op = 6'b000001;
    tick();
    tick();
    tick();
    checks++; if (bus.state !== 3'd4 || bus.acc_wr_en !== 1'b1)
      begin errors++; $display("FAIL lda_wb got st %0d wr %b exp 4 1", bus.state, bus.acc_wr_en); end
    rst = 1'b1;
    tick();
    checks++; if (bus.state !== 3'd0 || bus.retired !== 16'd0 || bus.acc_wr_en !== 1'b0)
      begin errors++; $display("FAIL lda_rst got st %0d ret %0d wr %b exp 0 0 0", bus.state, bus.retired, bus.acc_wr_en); end
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.acc_wr_en === 1'b1 || bus.state !== 3'd0) cnt++;
      tick();
    end
    rst = 1'b0;
    tick();
    checks++; if (cnt != 0 || bus.state !== 3'd1 || bus.retired !== 16'd0)
      begin errors++; $display("FAIL rst_hold got bad %0d st %0d ret %0d exp 0 1 0", cnt, bus.state, bus.retired); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_ret = 0;
    rst = 1'b1;
    bus.op = 6'd0;
    bus.acc_zero = 1'b0;
    test_reset();
    test_add();
    test_sta();
    test_jz();
    test_illegal();
    test_ops();
    test_halt_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
